// File: rtl/sub_32_if.sv
// sub_32_if -- operand/result bundle for the 32-bit subtractor.
// Optional macro: SUB_32_FLAGS_EN adds the zero/neg/borrow/ovf status lines.
interface sub_32_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] R;
  logic        out_valid;
`ifdef SUB_32_FLAGS_EN
  logic        zero;
  logic        neg;
  logic        borrow;
  logic        ovf;

  modport master (output in_valid, A, B,
                  input  R, out_valid, zero, neg, borrow, ovf);
  modport slave  (input  in_valid, A, B,
                  output R, out_valid, zero, neg, borrow, ovf);
`else
  modport master (output in_valid, A, B,
                  input  R, out_valid);
  modport slave  (input  in_valid, A, B,
                  output R, out_valid);
`endif
endinterface

// File: rtl/sub_32.sv
// sub_32 -- registered 32-bit subtractor, R = A + ~B + 1 over a ripple chain
// of full-adder cells, one-cycle latency, no backpressure.
// Optional macro: SUB_32_FLAGS_EN adds registered zero/neg/borrow/ovf flags.
module sub_32 (
  input  logic     clk,
  input  logic     rst_n,
  sub_32_if.slave  bus
);

  logic [31:0] nb;
  logic [31:0] diff;
  logic [31:0] r_q;
  logic        vld_q;

  assign nb = ~bus.B;

  // Ripple chain: each stage derives its carry-in from the previous cell,
  // so the carry of stage i lives in its own generate scope.
  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_fa
      logic cin;
      if (i == 0) begin : g_c0
        assign cin = 1'b1;
      end else begin : g_cn
        assign cin = (bus.A[i-1] & nb[i-1]) |
                     (g_fa[i-1].cin & (bus.A[i-1] ^ nb[i-1]));
      end
      assign diff[i] = bus.A[i] ^ nb[i] ^ cin;
    end
  endgenerate

  // Output register: capture on valid, hold otherwise; out_valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= 32'd0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) r_q <= diff;
    end
  end

  assign bus.R         = r_q;
  assign bus.out_valid = vld_q;

`ifdef SUB_32_FLAGS_EN
  logic cout31;
  logic zero_q, neg_q, borrow_q, ovf_q;

  // Carry-out of the top cell; its inverse is the unsigned borrow.
  assign cout31 = (bus.A[31] & nb[31]) | (g_fa[31].cin & (bus.A[31] ^ nb[31]));

  // Status flags, registered alongside R; reset reflects R == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.in_valid) begin
      zero_q   <= (diff == 32'd0);
      neg_q    <= diff[31];
      borrow_q <= ~cout31;
      ovf_q    <= (bus.A[31] != bus.B[31]) && (diff[31] != bus.A[31]);
    end
  end

  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sub_32.sv
// tb_sub_32 -- scoreboard bench for sub_32; expected results queued at drive
// time and compared when out_valid appears. Works with or without SUB_32_FLAGS_EN.
module tb_sub_32;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;   // {zero, neg, borrow, ovf}
  } exp_t;

  logic clk;
  logic rst_n;
  sub_32_if bus ();

  sub_32 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_sent    = 0;
  int          n_results = 0;
  logic [31:0] last_r;

  logic [31:0] ta [10] = '{32'd7, 32'd15, 32'd5, 32'd5, 32'h8000_0000,
                           32'h1234_5678, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] tb [10] = '{32'd32, 32'd16, 32'hFFFF_FFFD, 32'd4, 32'd1,
                           32'h1234_5678, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd1};
  logic [31:0] tr [10] = '{32'hFFFF_FFE7, 32'hFFFF_FFFF, 32'd8, 32'd1, 32'h7FFF_FFFF,
                           32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE};
  logic [3:0]  tf [10] = '{4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0001,
                           4'b1000, 4'b1000, 4'b0110, 4'b0111, 4'b0100};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.r = a - b;
    e.f = {(e.r == 32'd0), e.r[31], (a < b), ((a[31] != b[31]) && (e.r[31] != a[31]))};
    return e;
  endfunction

  task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef SUB_32_FLAGS_EN
    chk(tag, {28'd0, bus.zero, bus.neg, bus.borrow, bus.ovf}, {28'd0, exp});
`else
    if (exp === 4'bxxxx) $display("unreachable %s", tag);
`endif
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    n_sent++;
    last_r = e.r;
  endtask

  // Monitor: pop and compare one expected entry for every result cycle.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      n_results++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("R", bus.R, mon_e.r);
        check_flags("flags", mon_e.f);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 32'd5;
    bus.B        = 32'd3;

    // Held in reset with in_valid high: outputs stay at reset values.
    repeat (3) @(negedge clk);
    chk("rst_R", bus.R, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_flags("rst_flags", 4'b1000);

    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    // Directed vectors, back-to-back.
    for (int k = 0; k < 10; k++) begin
      e.r = tr[k];
      e.f = tf[k];
      send(ta[k], tb[k], e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_hold_R", bus.R, last_r);
    bus.A = $urandom;
    bus.B = $urandom;
    #2;
    chk("idle_input_change_R", bus.R, last_r);

    // Input changes after the capture edge must not alter the result.
    send(32'd1000, 32'd1, model(32'd1000, 32'd1));
    @(posedge clk);
    #2;
    bus.A        = ~bus.A;
    bus.B        = 32'h5555_5555;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("between_edges_R", bus.R, 32'd999);
    @(negedge clk);
    chk("between_edges_hold", bus.R, 32'd999);
    chk("between_edges_valid", {31'd0, bus.out_valid}, 32'd0);

    // Random back-to-back stream.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (k % 5 == 0) ? a : $urandom;
      send(a, b, model(a, b));
    end

    // Reset asserted between edges, mid-stream.
    send(32'd77, 32'd7, model(32'd77, 32'd7));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_R", bus.R, 32'd0);
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_flags("async_rst_flags", 4'b1000);
    bus.A = 32'd100;
    bus.B = 32'd58;
    repeat (2) @(negedge clk);
    chk("in_rst_R", bus.R, 32'd0);
    chk("in_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    rst_n = 1'b1;
    sb.push_back(model(32'd100, 32'd58));
    n_sent++;
    #1;
    chk("deassert_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("deassert_R", bus.R, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("first_after_rst_R", bus.R, 32'd42);
    chk("first_after_rst_valid", {31'd0, bus.out_valid}, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("result_count", n_results, n_sent);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
